data_mem_controller: RTL and testbench

//   Initiator side of the data-memory interface. Accepts one load/store request at a time

---
 rtl/data_mem_controller.sv | 160 ++++++++++++++++
 tb/tb_data_mem_controller.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_controller.sv
// Initiator for the 16-bit data memory: takes one load/store at a time from the CPU,
// drives registered memory strobes, waits out the read latency and returns a response.
module data_mem_controller #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned MEM_DEPTH    = 1024,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  stall,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] writeData,
  output logic                  memRead,
  output logic                  memWrite,
  input  logic [DATA_WIDTH-1:0] readData
);

  localparam int unsigned LAT_W = 4;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP
  } state_e;

  state_e                state_q, state_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  mem_rd_q, mem_rd_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rerr_q, rerr_d;
  logic                  rdy_q, rdy_d;
  logic                  stall_q, stall_d;
  logic                  addr_oor;

  assign addr_oor = ({1'b0, req_addr} >= DEPTH_LIMIT);

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    mem_rd_d = 1'b0;
    mem_wr_d = 1'b0;
    rvalid_d = rvalid_q;
    rerr_d   = rerr_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && rdy_q) begin
          if (addr_oor) begin
            state_d  = S_RESP;
            rvalid_d = 1'b1;
            rerr_d   = 1'b1;
            rdata_d  = '0;
          end else begin
            state_d = S_ACCESS;
            addr_d  = req_addr;
            if (req_write) begin
              mem_wr_d = 1'b1;
              wdata_d  = req_wdata;
            end else begin
              mem_rd_d = 1'b1;
            end
          end
        end
      end
      S_ACCESS: begin
        // The strobe register itself records which operation is in flight
        if (mem_wr_q) begin
          state_d  = S_RESP;
          rvalid_d = 1'b1;
          rerr_d   = 1'b0;
          rdata_d  = '0;
        end else begin
          state_d = S_WAIT;
          lat_d   = LAT_LOAD;
        end
      end
      S_WAIT: begin
        if (lat_q == '0) begin
          state_d  = S_RESP;
          rdata_d  = readData;
          rvalid_d = 1'b1;
          rerr_d   = 1'b0;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d  = S_IDLE;
          rvalid_d = 1'b0;
          rerr_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rdy_d   = (state_d == S_IDLE);
    stall_d = ~rdy_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      lat_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rdy_q    <= 1'b1;
      stall_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
      rdy_q    <= rdy_d;
      stall_q  <= stall_d;
    end
  end

  assign req_ready  = rdy_q;
  assign stall      = stall_q;
  assign resp_valid = rvalid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = rerr_q;
  assign addr       = addr_q;
  assign writeData  = wdata_q;
  assign memRead    = mem_rd_q;
  assign memWrite   = mem_wr_q;

endmodule

// File: tb/tb_data_mem_controller.sv
// Bench for data_mem_controller: two instances (read latency 1 and 3), a latency-aware
// memory, and a transaction-level timing model checked against the outputs every cycle.
module tb_data_mem_controller;

  localparam int N     = 2;
  localparam int DEPTH = 1024;

  logic        clk;
  logic        mem_init;
  logic        rst        [N];
  logic        req_valid  [N];
  logic        req_ready  [N];
  logic        req_write  [N];
  logic [15:0] req_addr   [N];
  logic [15:0] req_wdata  [N];
  logic        resp_valid [N];
  logic        resp_ready [N];
  logic [15:0] resp_rdata [N];
  logic        resp_err   [N];
  logic        stall      [N];
  logic [15:0] addr       [N];
  logic [15:0] writeData  [N];
  logic        memRead    [N];
  logic        memWrite   [N];
  logic [15:0] readData   [N];

  data_mem_controller #(.READ_LATENCY(1)) u_dut0 (
    .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .stall(stall[0]), .addr(addr[0]), .writeData(writeData[0]),
    .memRead(memRead[0]), .memWrite(memWrite[0]), .readData(readData[0])
  );

  data_mem_controller #(.READ_LATENCY(3)) u_dut1 (
    .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .stall(stall[1]), .addr(addr[1]), .writeData(writeData[1]),
    .memRead(memRead[1]), .memWrite(memWrite[1]), .readData(readData[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [15:0] init_word(input int a);
    return 16'hC000 ^ 16'(a);
  endfunction

  // Memory: writes on memWrite, read data appears READ_LATENCY cycles after memRead
  logic [15:0] env_mem [N][DEPTH];
  logic [15:0] pd      [N][4];
  logic        pv      [N][4];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (mem_init) begin
        for (int a = 0; a < DEPTH; a++) env_mem[i][a] <= init_word(a);
      end else if (memWrite[i] && addr[i] < 16'(DEPTH)) begin
        env_mem[i][addr[i][9:0]] <= writeData[i];
      end
      pv[i][0] <= memRead[i];
      pd[i][0] <= env_mem[i][addr[i][9:0]];
      for (int s = 1; s < 4; s++) begin
        pv[i][s] <= pv[i][s-1];
        pd[i][s] <= pd[i][s-1];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      readData[i] = pv[i][lat_of(i)-1] ? pd[i][lat_of(i)-1] : 16'h5A5A;
    end
  end

  // Transaction-level expectation per instance
  int          cyc;
  int          checks;
  int          errors;
  bit          m_live  [N];
  bit          m_busy  [N];
  bit          m_store [N];
  bit          m_err   [N];
  int          m_acc   [N];
  int          m_rcyc  [N];
  logic [15:0] m_rdata [N];
  logic [15:0] m_laddr [N];
  logic [15:0] m_lwd   [N];
  logic [15:0] m_mem   [N][DEPTH];

  task automatic chk(input string name, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cycle %0d: got 0x%0h expected 0x%0h", name, i, cyc, act, exp);
    end
  endtask

  task automatic model_edge(input int i);
    logic [15:0] a;
    if (rst[i]) begin
      m_live[i]  = 1'b1;
      m_busy[i]  = 1'b0;
      m_laddr[i] = 16'h0;
      m_lwd[i]   = 16'h0;
    end else if (m_live[i]) begin
      if (m_busy[i]) begin
        if (cyc >= m_rcyc[i] && resp_ready[i]) m_busy[i] = 1'b0;
      end else if (req_valid[i]) begin
        a          = req_addr[i];
        m_busy[i]  = 1'b1;
        m_acc[i]   = cyc;
        m_store[i] = req_write[i];
        m_err[i]   = (a >= 16'(DEPTH));
        if (m_err[i])        m_rcyc[i] = cyc + 1;
        else if (m_store[i]) m_rcyc[i] = cyc + 2;
        else                 m_rcyc[i] = cyc + 2 + lat_of(i);
        m_rdata[i] = (m_err[i] || m_store[i]) ? 16'h0 : m_mem[i][a[9:0]];
        if (!m_err[i]) m_laddr[i] = a;
        if (m_store[i] && !m_err[i]) begin
          m_mem[i][a[9:0]] = req_wdata[i];
          m_lwd[i]         = req_wdata[i];
        end
      end
    end
  endtask

  task automatic compare(input int i);
    int k;
    bit e_rv, e_mw, e_mr;
    if (!m_live[i]) return;
    k    = cyc - m_acc[i];
    e_rv = m_busy[i] && (cyc >= m_rcyc[i]);
    e_mw = m_busy[i] && !m_err[i] && m_store[i] && (k == 1);
    e_mr = m_busy[i] && !m_err[i] && !m_store[i] && (k == 1);
    chk("req_ready", i, 32'(req_ready[i]), 32'(!m_busy[i]));
    chk("stall", i, 32'(stall[i]), 32'(m_busy[i]));
    chk("memWrite", i, 32'(memWrite[i]), 32'(e_mw));
    chk("memRead", i, 32'(memRead[i]), 32'(e_mr));
    chk("resp_valid", i, 32'(resp_valid[i]), 32'(e_rv));
    chk("addr", i, 32'(addr[i]), 32'(m_laddr[i]));
    chk("writeData", i, 32'(writeData[i]), 32'(m_lwd[i]));
    if (e_rv) begin
      chk("resp_rdata", i, 32'(resp_rdata[i]), 32'(m_rdata[i]));
      chk("resp_err", i, 32'(resp_err[i]), 32'(m_err[i]));
    end else begin
      chk("resp_err_idle", i, 32'(resp_err[i]), 32'(0));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < N; i++) model_edge(i);
    cyc++;
    @(negedge clk);
    for (int i = 0; i < N; i++) compare(i);
  endtask

  task automatic issue(input int i, input logic w, input logic [15:0] a, input logic [15:0] d,
                       output int acc);
    int n = 0;
    while (!req_ready[i] && n < 20) begin
      tick();
      n++;
    end
    if (!req_ready[i]) chk("req_ready_timeout", i, 32'(req_ready[i]), 32'(1));
    req_valid[i] = 1'b1;
    req_write[i] = w;
    req_addr[i]  = a;
    req_wdata[i] = d;
    acc = cyc;
    tick();
    req_valid[i] = 1'b0;
    req_write[i] = ~w;
    req_addr[i]  = 16'h0F0F;
    req_wdata[i] = 16'hA0A0;
  endtask

  task automatic wait_resp(input int i, output int rc);
    int n = 0;
    while (!resp_valid[i] && n < 40) begin
      tick();
      n++;
    end
    if (!resp_valid[i]) chk("resp_timeout", i, 32'(resp_valid[i]), 32'(1));
    rc = cyc;
  endtask

  initial begin
    int acc, rc;
    logic [15:0] held;
    cyc      = 0;
    checks   = 0;
    errors   = 0;
    mem_init = 1'b1;
    for (int i = 0; i < N; i++) begin
      m_live[i]     = 1'b0;
      m_busy[i]     = 1'b0;
      m_acc[i]      = 0;
      m_rcyc[i]     = 0;
      rst[i]        = 1'b1;
      req_valid[i]  = 1'b0;
      req_write[i]  = 1'b0;
      req_addr[i]   = 16'h0;
      req_wdata[i]  = 16'h0;
      resp_ready[i] = 1'b1;
      for (int a = 0; a < DEPTH; a++) m_mem[i][a] = init_word(a);
    end
    tick();
    mem_init = 1'b0;
    tick();
    for (int i = 0; i < N; i++) rst[i] = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk("rst_req_ready", i, 32'(req_ready[i]), 32'(1));
      chk("rst_addr", i, 32'(addr[i]), 32'(0));
      chk("rst_writeData", i, 32'(writeData[i]), 32'(0));
      chk("rst_resp_rdata", i, 32'(resp_rdata[i]), 32'(0));
    end
    tick();

    // Store 0x0005 <- 0xBEEF
    issue(0, 1'b1, 16'h0005, 16'hBEEF, acc);
    chk("t1_memWrite", 0, 32'(memWrite[0]), 32'(1));
    chk("t1_addr", 0, 32'(addr[0]), 32'h0005);
    chk("t1_writeData", 0, 32'(writeData[0]), 32'hBEEF);
    wait_resp(0, rc);
    chk("t1_latency", 0, 32'(rc - acc), 32'(2));
    chk("t1_rdata", 0, 32'(resp_rdata[0]), 32'h0);
    tick();

    // Load 0x0005, latency 1
    issue(0, 1'b0, 16'h0005, 16'h1111, acc);
    chk("t2_memRead", 0, 32'(memRead[0]), 32'(1));
    wait_resp(0, rc);
    chk("t2_latency", 0, 32'(rc - acc), 32'(3));
    chk("t2_rdata", 0, 32'(resp_rdata[0]), 32'hBEEF);
    tick();

    // Out-of-range load
    issue(0, 1'b0, 16'h0400, 16'h0, acc);
    chk("t3_memRead", 0, 32'(memRead[0]), 32'(0));
    wait_resp(0, rc);
    chk("t3_latency", 0, 32'(rc - acc), 32'(1));
    chk("t3_err", 0, 32'(resp_err[0]), 32'(1));
    chk("t3_rdata", 0, 32'(resp_rdata[0]), 32'h0);
    tick();

    // Response back-pressure
    resp_ready[0] = 1'b0;
    issue(0, 1'b0, 16'h0007, 16'h0, acc);
    wait_resp(0, rc);
    held = resp_rdata[0];
    chk("t4_rdata", 0, 32'(held), 32'hC007);
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("t4_hold_valid", 0, 32'(resp_valid[0]), 32'(1));
      chk("t4_hold_rdata", 0, 32'(resp_rdata[0]), 32'(held));
      chk("t4_hold_stall", 0, 32'(stall[0]), 32'(1));
    end
    resp_ready[0] = 1'b1;
    tick();
    chk("t4_idle", 0, 32'(req_ready[0]), 32'(1));

    // Reset during the WAIT phase of a latency-3 load
    issue(1, 1'b0, 16'h0010, 16'h0, acc);
    tick();
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    chk("t5_resp_valid", 1, 32'(resp_valid[1]), 32'(0));
    chk("t5_req_ready", 1, 32'(req_ready[1]), 32'(1));
    for (int n = 0; n < 6; n++) begin
      tick();
      chk("t5_no_resp", 1, 32'(resp_valid[1]), 32'(0));
    end

    // Back-to-back store then load at the top word, latency 3
    issue(1, 1'b1, 16'h03FF, 16'h1234, acc);
    wait_resp(1, rc);
    chk("t6_store_latency", 1, 32'(rc - acc), 32'(2));
    tick();
    issue(1, 1'b0, 16'h03FF, 16'h0, acc);
    wait_resp(1, rc);
    chk("t6_load_latency", 1, 32'(rc - acc), 32'(5));
    chk("t6_rdata", 1, 32'(resp_rdata[1]), 32'h1234);
    tick();

    // Out-of-range store
    issue(1, 1'b1, 16'hFFFF, 16'h7777, acc);
    wait_resp(1, rc);
    chk("t7_latency", 1, 32'(rc - acc), 32'(1));
    chk("t7_err", 1, 32'(resp_err[1]), 32'(1));
    chk("t7_writeData", 1, 32'(writeData[1]), 32'h1234);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
